sync_ram_dp: RTL and testbench

Parametrised simple-dual-port synchronous RAM for the pico MIPS datapath: one write port and one read port on the same clock, with per-lane write masking, a selectable read-during-write mode, and a hardware clear sequencer that zeroes the whole array after reset. It replaces the single-port `sync_ram` wherever data memory or scratch storage needs a read and a write in the same cycle.

---
 rtl/sync_ram_pkg.sv | 34 +++
 rtl/sync_ram_clear_seq.sv | 49 ++++
 rtl/sync_ram_dp.sv | 110 +++++++++++
 tb/tb_sync_ram_dp.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_ram_pkg.sv
// Shared types and helpers for the simple-dual-port RAM family.
// Holds the sequencer state encoding, read-during-write mode constants and lane merge.
package sync_ram_pkg;

   typedef enum logic {
      CLEAR,
      RUN
   } ram_state_t;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   // Widest word and lane count the merge helper can serve; callers cast to and from these.
   localparam int MAX_N     = 256;
   localparam int MAX_LANES = 32;

   // Takes each lane whose mask bit is set from newWord, every other bit from oldWord.
   function automatic logic [MAX_N-1:0] laneMerge(
      input logic [MAX_N-1:0]     oldWord,
      input logic [MAX_N-1:0]     newWord,
      input logic [MAX_LANES-1:0] mask,
      input int                   laneW
   );
      logic [MAX_N-1:0]     bitMask;
      logic [MAX_LANES-1:0] shifted;
      bitMask = '0;
      for (int b = 0; b < MAX_N; b++) begin
         shifted = mask >> (b / laneW);
         bitMask = bitMask | (MAX_N'(shifted[0]) << b);
      end
      return (oldWord & ~bitMask) | (newWord & bitMask);
   endfunction

endpackage

// File: rtl/sync_ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once with a zero write, then opens the RAM.
module sync_ram_clear_seq
   import sync_ram_pkg::*;
#(
   parameter int M          = 32,
   parameter int INIT_CLEAR = 1,
   parameter int AddrSz     = (M > 1) ? $clog2(M) : 1
) (
   input  logic              clk,
   input  logic              reset,
   output logic              ready,
   output logic              clr_we,
   output logic [AddrSz-1:0] clr_addr
);

   localparam logic [AddrSz-1:0] LastAddr = AddrSz'(M - 1);

   ram_state_t        r_state;
   logic [AddrSz-1:0] r_ptr;
   logic              r_ready;

   // ready is its own register so it only ever reflects the settled state, never the inputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= (INIT_CLEAR != 0) ? CLEAR : RUN;
         r_ptr   <= '0;
         r_ready <= 1'b0;
      end else begin
         case (r_state)
            CLEAR: begin
               if (r_ptr == LastAddr) begin
                  r_state <= RUN;
                  r_ready <= 1'b1;
               end else begin
                  r_ptr <= r_ptr + 1'b1;
               end
            end
            RUN: begin
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign ready    = r_ready;
   assign clr_we   = (r_state == CLEAR);
   assign clr_addr = r_ptr;

endmodule

// File: rtl/sync_ram_dp.sv
// Simple-dual-port synchronous RAM with lane-masked writes, selectable read-during-write
// behaviour and a hardware clear after reset.
module sync_ram_dp
   import sync_ram_pkg::*;
#(
   parameter int N          = 32,
   parameter int M          = 32,
   parameter int LANES      = 4,
   parameter int RDW_MODE   = 0,
   parameter int INIT_CLEAR = 1,
   parameter int AddrSz     = (M > 1) ? $clog2(M) : 1
) (
   input  logic              clk,
   input  logic              reset,
   output logic              ready,
   input  logic              w_en,
   input  logic [AddrSz-1:0] w_addr,
   input  logic [N-1:0]      w_data,
   input  logic [LANES-1:0]  w_mask,
   input  logic              r_en,
   input  logic [AddrSz-1:0] r_addr,
   output logic [N-1:0]      r_data,
   output logic              r_valid
);

   localparam int LaneW = N / LANES;
   localparam logic [AddrSz:0] Depth = (AddrSz + 1)'(M);

   logic [N-1:0] r_mem [M];
   logic [N-1:0] r_rdData;
   logic         r_rdValid;

   logic              w_ready;
   logic              w_clrWe;
   logic [AddrSz-1:0] w_clrAddr;

   logic              w_wrInRange;
   logic              w_rdInRange;
   logic              w_userWr;
   logic [N-1:0]      w_wrMerged;
   logic              w_portWe;
   logic [AddrSz-1:0] w_portAddr;
   logic [N-1:0]      w_portData;
   logic [N-1:0]      w_rdOld;
   logic [N-1:0]      w_rdBypass;
   logic [N-1:0]      w_rdNext;

   sync_ram_clear_seq #(
      .M          (M),
      .INIT_CLEAR (INIT_CLEAR),
      .AddrSz     (AddrSz)
   ) u_clearSeq (
      .clk      (clk),
      .reset    (reset),
      .ready    (w_ready),
      .clr_we   (w_clrWe),
      .clr_addr (w_clrAddr)
   );

   assign ready = w_ready;

   assign w_wrInRange = ({1'b0, w_addr} < Depth);
   assign w_rdInRange = ({1'b0, r_addr} < Depth);
   assign w_userWr    = w_ready & w_en & w_wrInRange;

   assign w_wrMerged = N'(laneMerge(MAX_N'(r_mem[w_addr]), MAX_N'(w_data),
                                    MAX_LANES'(w_mask), LaneW));

   // While clearing, the sequencer owns the single write port and user writes are dropped.
   assign w_portWe   = w_clrWe | w_userWr;
   assign w_portAddr = w_clrWe ? w_clrAddr : w_addr;
   assign w_portData = w_clrWe ? '0 : w_wrMerged;

   // Same-address bypass only takes effect in new-data mode; out-of-range reads return zero.
   assign w_rdOld    = r_mem[r_addr];
   assign w_rdBypass = N'(laneMerge(MAX_N'(w_rdOld), MAX_N'(w_data),
                                    MAX_LANES'(w_mask), LaneW));
   always_comb begin
      w_rdNext = '0;
      if (w_rdInRange) begin
         if ((RDW_MODE == RDW_NEW) && w_en && (w_addr == r_addr)) begin
            w_rdNext = w_rdBypass;
         end else begin
            w_rdNext = w_rdOld;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_portWe) begin
         r_mem[w_portAddr] <= w_portData;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdData  <= '0;
         r_rdValid <= 1'b0;
      end else if (w_ready && r_en) begin
         r_rdData  <= w_rdNext;
         r_rdValid <= 1'b1;
      end else begin
         r_rdValid <= 1'b0;
      end
   end

   assign r_data  = r_rdData;
   assign r_valid = r_rdValid;

endmodule

// File: tb/tb_sync_ram_dp.sv
// Bench for sync_ram_dp: three instances (old-data, new-data, 20-word) driven in lockstep
// and compared every cycle against a lane-level array model.
module tb_sync_ram_dp;

   logic        clk;
   logic        reset;
   logic        wEn;
   logic [4:0]  wAddr;
   logic [31:0] wData;
   logic [3:0]  wMask;
   logic        rEn;
   logic [4:0]  rAddr;

   logic [2:0]  readyV;
   logic [2:0]  validV;
   logic [31:0] dataV [3];

   int tests = 0;
   int fails = 0;

   logic [31:0] mdl [3][32];
   int          mdlM [3]   = '{32, 32, 20};
   int          mdlRdw [3] = '{0, 1, 0};
   int          remaining [3];
   logic        expReady [3] = '{1'b0, 1'b0, 1'b0};
   logic        expValid [3];
   logic [31:0] expData [3];

   sync_ram_dp #(.N(32), .M(32), .LANES(4), .RDW_MODE(0), .INIT_CLEAR(1)) dutOld (
      .clk(clk), .reset(reset), .ready(readyV[0]),
      .w_en(wEn), .w_addr(wAddr), .w_data(wData), .w_mask(wMask),
      .r_en(rEn), .r_addr(rAddr), .r_data(dataV[0]), .r_valid(validV[0])
   );

   sync_ram_dp #(.N(32), .M(32), .LANES(4), .RDW_MODE(1), .INIT_CLEAR(1)) dutNew (
      .clk(clk), .reset(reset), .ready(readyV[1]),
      .w_en(wEn), .w_addr(wAddr), .w_data(wData), .w_mask(wMask),
      .r_en(rEn), .r_addr(rAddr), .r_data(dataV[1]), .r_valid(validV[1])
   );

   sync_ram_dp #(.N(32), .M(20), .LANES(4), .RDW_MODE(0), .INIT_CLEAR(1)) dutShort (
      .clk(clk), .reset(reset), .ready(readyV[2]),
      .w_en(wEn), .w_addr(wAddr), .w_data(wData), .w_mask(wMask),
      .r_en(rEn), .r_addr(rAddr), .r_data(dataV[2]), .r_valid(validV[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] mergeLanes(input logic [31:0] oldW, input logic [31:0] newW,
                                              input logic [3:0] mask);
      logic [31:0] res;
      res = oldW;
      for (int l = 0; l < 4; l++) begin
         if (mask[l]) res[l*8 +: 8] = newW[l*8 +: 8];
      end
      return res;
   endfunction

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Advances every model copy by one clock edge using the inputs presented at that edge.
   task automatic modelEdge(input logic rst, input logic wen, input logic [4:0] wa,
                            input logic [31:0] wd, input logic [3:0] wm,
                            input logic ren, input logic [4:0] ra);
      logic [31:0] val;
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            remaining[k] = mdlM[k];
            expReady[k] = 1'b0;
            expValid[k] = 1'b0;
            expData[k]  = 32'h0;
         end else if (!expReady[k]) begin
            mdl[k][mdlM[k] - remaining[k]] = 32'h0;
            remaining[k]--;
            expValid[k] = 1'b0;
            if (remaining[k] == 0) expReady[k] = 1'b1;
         end else begin
            if (ren) begin
               expValid[k] = 1'b1;
               if (int'(ra) < mdlM[k]) begin
                  val = mdl[k][ra];
                  if (mdlRdw[k] == 1 && wen && wa == ra) val = mergeLanes(val, wd, wm);
                  expData[k] = val;
               end else begin
                  expData[k] = 32'h0;
               end
            end else begin
               expValid[k] = 1'b0;
            end
            if (wen && int'(wa) < mdlM[k]) mdl[k][wa] = mergeLanes(mdl[k][wa], wd, wm);
         end
      end
   endtask

   task automatic checkOutput();
      for (int k = 0; k < 3; k++) begin
         checkVal($sformatf("ready[%0d]", k), {31'h0, readyV[k]}, {31'h0, expReady[k]});
         checkVal($sformatf("r_valid[%0d]", k), {31'h0, validV[k]}, {31'h0, expValid[k]});
         checkVal($sformatf("r_data[%0d]", k), dataV[k], expData[k]);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic wen, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [3:0] wm,
                                input logic ren, input logic [4:0] ra);
      reset = rst; wEn = wen; wAddr = wa; wData = wd; wMask = wm; rEn = ren; rAddr = ra;
      @(posedge clk);
      modelEdge(rst, wen, wa, wd, wm, ren, ra);
      #1;
      checkOutput();
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
   endtask

   // Steps idle (or with random writes) until the 32-word instance reports ready; returns the step count.
   task automatic waitReady(input logic noisy, output int cnt);
      cnt = 0;
      for (int i = 1; i <= 100; i++) begin
         if (noisy)
            applyStimulus(1'b0, 1'b1, 5'($urandom_range(0, 31)), $urandom, 4'hF, 1'b1,
                          5'($urandom_range(0, 31)));
         else
            idle();
         cnt = i;
         if (readyV[0]) break;
      end
   endtask

   initial begin
      int cnt;
      reset = 1'b1; wEn = 1'b0; wAddr = '0; wData = '0; wMask = '0; rEn = 1'b0; rAddr = '0;

      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
      waitReady(1'b0, cnt);
      checkVal("initial_clear_cycles", 32'(cnt), 32'd32);

      // Clear wipes a previously written word.
      applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd5);
      checkVal("preload_rd5", dataV[0], 32'hDEADBEEF);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
      waitReady(1'b0, cnt);
      checkVal("reclear_cycles", 32'(cnt), 32'd32);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd5);
      checkVal("cleared_rd5", dataV[0], 32'h0);

      // Masked write.
      applyStimulus(1'b0, 1'b1, 5'd12, 32'h11223344, 4'b1111, 1'b0, 5'd0);
      applyStimulus(1'b0, 1'b1, 5'd12, 32'hAABBCCDD, 4'b0101, 1'b0, 5'd0);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd12);
      checkVal("masked_rd12", dataV[0], 32'h11BB33DD);
      checkVal("masked_valid", {31'h0, validV[0]}, 32'd1);
      idle();
      checkVal("idle_valid_low", {31'h0, validV[0]}, 32'd0);
      checkVal("idle_data_held", dataV[0], 32'h11BB33DD);

      // Same-address read during write.
      applyStimulus(1'b0, 1'b1, 5'd3, 32'hFFFFFFFF, 4'b0011, 1'b1, 5'd3);
      checkVal("rdw_old", dataV[0], 32'h00000000);
      checkVal("rdw_new", dataV[1], 32'h0000FFFF);

      // Different-address read and write.
      applyStimulus(1'b0, 1'b1, 5'd12, 32'd136, 4'hF, 1'b0, 5'd0);
      applyStimulus(1'b0, 1'b1, 5'd2, 32'h55, 4'hF, 1'b1, 5'd12);
      checkVal("diff_rd12", dataV[0], 32'd136);
      checkVal("diff_rd12_new", dataV[1], 32'd136);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd2);
      checkVal("diff_rd2", dataV[0], 32'h55);

      // Out-of-range on the 20-word instance.
      applyStimulus(1'b0, 1'b1, 5'd25, 32'h1234, 4'hF, 1'b0, 5'd0);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd25);
      checkVal("oor_rd25", dataV[2], 32'h0);
      checkVal("oor_valid", {31'h0, validV[2]}, 32'd1);
      checkVal("inrange_rd25", dataV[0], 32'h1234);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd5);
      checkVal("oor_rd5", dataV[2], 32'h0);

      // Reset mid-clear with user traffic that must be ignored.
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
      for (int i = 0; i < 10; i++)
         applyStimulus(1'b0, 1'b1, 5'($urandom_range(0, 31)), $urandom, 4'hF, 1'b1, 5'd0);
      checkVal("midclear_not_ready", {31'h0, readyV[0]}, 32'd0);
      applyStimulus(1'b1, 1'b1, 5'd7, 32'hCAFEF00D, 4'hF, 1'b0, 5'd0);
      waitReady(1'b1, cnt);
      checkVal("midclear_cycles", 32'(cnt), 32'd32);
      for (int a = 0; a < 32; a++) begin
         applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'(a));
         checkVal($sformatf("zero_rd%0d", a), dataV[0], 32'h0);
      end

      // Random traffic against the model, including rare resets.
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
